// File: rtl/cs_enc_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : cs_enc_rr_sched
// Purpose  : Round-robin scheduler that shares one in-order, fixed-latency
//            encoder core among N requesters. Each issue is tagged with its
//            requester ID, and results return in issue order through a
//            credit-protected result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module cs_enc_rr_sched #(
  parameter int K     = 5,
  parameter int M     = 3,
  parameter int L     = 11,
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [N-1:0]                    req_valid,
  output logic [N-1:0]                    req_ready,
  input  logic [N*M*(L-1)-1:0]            req_data,
  output logic                            core_in_valid,
  output logic [M*(L-1)-1:0]              core_din,
  input  logic                            core_out_valid,
  input  logic [K*(L-1)-1:0]              core_dout,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [K*(L-1)-1:0]              res_data,
  output logic [$clog2(N)-1:0]            res_id,
  output logic                            busy,
  output logic                            err
);

  localparam int c_din_w  = M * (L - 1);
  localparam int c_dout_w = K * (L - 1);
  localparam int c_idw    = $clog2(N);
  localparam int c_aw     = $clog2(DEPTH);
  localparam int c_cw     = c_aw + 1;
  localparam logic [c_idw:0]  c_n_ext   = (c_idw + 1)'(N);
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_cw:0]   c_depth_s = (c_cw + 1)'(DEPTH);

  // Round-robin pointer: the requester granted most recently
  logic [c_idw-1:0]  r_ptr;
  // Issues not yet returned by the core, and result FIFO occupancy
  logic [c_cw-1:0]   r_inflight;
  logic [c_cw-1:0]   r_occ;
  logic              r_err;

  // ID tag FIFO; its fill level always equals r_inflight
  logic [c_idw-1:0]  r_tag_mem [DEPTH];
  logic [c_aw-1:0]   r_tag_wptr;
  logic [c_aw-1:0]   r_tag_rptr;

  // Result FIFO holding {id, data}
  logic [c_idw+c_dout_w-1:0] r_res_mem [DEPTH];
  logic [c_aw-1:0]   r_res_wptr;
  logic [c_aw-1:0]   r_res_rptr;

  logic [N-1:0]      w_grant;
  logic [c_idw-1:0]  w_gnt_idx;
  logic              w_found;
  logic [c_din_w-1:0] w_din;
  logic [c_cw:0]     w_sum;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_ret_ok;
  logic              w_res_pop;
  logic              w_res_full;
  logic              w_res_push;

  // Grant the first valid requester after r_ptr, wrapping modulo N
  always_comb begin : p_grant
    logic [c_idw:0] j_ext;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    j_ext     = '0;
    for (int k = 1; k <= N; k++) begin
      j_ext = {1'b0, r_ptr} + (c_idw + 1)'(k);
      if (j_ext >= c_n_ext) begin
        j_ext = j_ext - c_n_ext;
      end
      if (!w_found && req_valid[j_ext[c_idw-1:0]]) begin
        w_found                    = 1'b1;
        w_gnt_idx                  = j_ext[c_idw-1:0];
        w_grant[j_ext[c_idw-1:0]]  = 1'b1;
      end
    end
  end

  // Select the granted requester's data slice
  always_comb begin : p_din_mux
    w_din = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_din = req_data[i*c_din_w +: c_din_w];
      end
    end
  end

  // Credit: never accept more work than the result FIFO can absorb
  assign w_sum       = {1'b0, r_inflight} + {1'b0, r_occ};
  assign w_credit_ok = w_sum < c_depth_s;
  assign w_issue     = w_found & w_credit_ok;

  assign req_ready     = w_credit_ok ? w_grant : '0;
  assign core_in_valid = w_issue;
  assign core_din      = w_issue ? w_din : '0;

  // A return is only honoured when a tag is outstanding; a full FIFO without
  // a simultaneous pop drops the result but still consumes the tag
  assign w_ret_ok   = core_out_valid & (r_inflight != '0);
  assign w_res_pop  = (r_occ != '0) & res_ready;
  assign w_res_full = (r_occ == c_depth);
  assign w_res_push = w_ret_ok & (~w_res_full | w_res_pop);

  // Control state: pointers, counters, RR pointer and sticky error
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ptr      <= c_idw'(N - 1);
      r_inflight <= '0;
      r_occ      <= '0;
      r_err      <= 1'b0;
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      r_res_wptr <= '0;
      r_res_rptr <= '0;
    end else begin
      if (w_issue) begin
        r_ptr      <= w_gnt_idx;
        r_tag_wptr <= r_tag_wptr + 1'b1;
      end
      if (w_ret_ok) begin
        r_tag_rptr <= r_tag_rptr + 1'b1;
      end
      if (w_res_push) begin
        r_res_wptr <= r_res_wptr + 1'b1;
      end
      if (w_res_pop) begin
        r_res_rptr <= r_res_rptr + 1'b1;
      end
      r_inflight <= r_inflight + c_cw'(w_issue) - c_cw'(w_ret_ok);
      r_occ      <= r_occ + c_cw'(w_res_push) - c_cw'(w_res_pop);
      if ((core_out_valid && (r_inflight == '0)) ||
          (w_ret_ok && w_res_full && !w_res_pop)) begin
        r_err <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are qualified by the counters, so no reset
  always_ff @(posedge aclk) begin
    if (w_issue) begin
      r_tag_mem[r_tag_wptr] <= w_gnt_idx;
    end
    if (w_res_push) begin
      r_res_mem[r_res_wptr] <= {r_tag_mem[r_tag_rptr], core_dout};
    end
  end

  assign res_valid          = (r_occ != '0);
  assign {res_id, res_data} = res_valid ? r_res_mem[r_res_rptr] : '0;
  assign busy               = (r_inflight != '0) | (r_occ != '0);
  assign err                = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cs_enc_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_enc_rr_sched
// Purpose  : Self-checking bench for cs_enc_rr_sched with a 2-register core
//            model and a reference scheduler/scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_enc_rr_sched;

  localparam int K     = 5;
  localparam int M     = 3;
  localparam int L     = 11;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int DIN   = M * (L - 1);
  localparam int DOUT  = K * (L - 1);
  localparam int IDW   = $clog2(N);

  logic                aclk;
  logic                aresetn;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*DIN-1:0]    req_data;
  logic                core_in_valid;
  logic [DIN-1:0]      core_din;
  logic                core_out_valid;
  logic [DOUT-1:0]     core_dout;
  logic                res_valid;
  logic                res_ready;
  logic [DOUT-1:0]     res_data;
  logic [IDW-1:0]      res_id;
  logic                busy;
  logic                err;

  // Core model: two pipeline registers, plus a stray-strobe injector
  logic                p0_v, p1_v, inj;
  logic [DIN-1:0]      p0_d, p1_d;

  // Reference model state
  int                  m_ptr;
  logic                m_err;
  logic [63:0]         infl_q[$];
  logic [63:0]         res_q[$];

  int                  n_cmp;
  int                  n_bad;

  cs_enc_rr_sched #(.K(K), .M(M), .L(L), .N(N), .DEPTH(DEPTH)) u_dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .core_in_valid  (core_in_valid),
    .core_din       (core_din),
    .core_out_valid (core_out_valid),
    .core_dout      (core_dout),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_id         (res_id),
    .busy           (busy),
    .err            (err)
  );

  function automatic logic [DOUT-1:0] enc(input logic [DIN-1:0] d);
    return {d[19:0] ^ d[29:10], d};
  endfunction

  assign core_out_valid = p1_v | inj;
  assign core_dout      = inj ? {DOUT{1'b1}} : enc(p1_d);

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DIN-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[N*DIN-1:0];
  endfunction

  // One clock cycle: predict and compare at negedge, then advance the model
  task automatic tick();
    logic [N-1:0]   eg;
    logic [IDW-1:0] gid;
    logic           ecr, ehs, ret, pop, full, rst_n, cv;
    logic [DIN-1:0] cd, gdat;
    logic [63:0]    e, h;
    int             j;
    @(negedge aclk);
    eg  = '0;
    gid = '0;
    for (int k = 1; k <= N; k++) begin
      j = (m_ptr + k) % N;
      if (eg == '0 && req_valid[j]) begin
        eg[j] = 1'b1;
        gid   = j[IDW-1:0];
      end
    end
    gdat = req_data[gid*DIN +: DIN];
    ecr  = (infl_q.size() + res_q.size()) < DEPTH;
    ehs  = (eg != '0) && ecr;
    check("req_ready", 64'(req_ready), ecr ? 64'(eg) : 64'd0);
    check("core_in_valid", 64'(core_in_valid), 64'(ehs));
    check("core_din", 64'(core_din), ehs ? 64'(gdat) : 64'd0);
    check("res_valid", 64'(res_valid), 64'(res_q.size() != 0));
    h = (res_q.size() != 0) ? res_q[0] : 64'd0;
    check("res_id_data", {12'd0, res_id, res_data}, h);
    check("busy", 64'(busy), 64'((infl_q.size() + res_q.size()) != 0));
    check("err", 64'(err), 64'(m_err));
    ret   = core_out_valid;
    pop   = (res_q.size() != 0) && res_ready;
    full  = (res_q.size() == DEPTH);
    rst_n = aresetn;
    cv    = core_in_valid;
    cd    = core_din;
    e     = '0;
    e[DOUT-1:0]      = enc(gdat);
    e[DOUT +: IDW]   = gid;
    @(posedge aclk);
    #1;
    if (!rst_n) begin
      infl_q.delete();
      res_q.delete();
      m_ptr = N - 1;
      m_err = 1'b0;
      p0_v  = 1'b0;
      p1_v  = 1'b0;
    end else begin
      if (pop) void'(res_q.pop_front());
      if (ret) begin
        if (infl_q.size() == 0) begin
          m_err = 1'b1;
        end else begin
          h = infl_q.pop_front();
          if (!full || pop) res_q.push_back(h);
          else m_err = 1'b1;
        end
      end
      if (ehs) begin
        infl_q.push_back(e);
        m_ptr = int'(gid);
      end
      p1_v = p0_v;
      p1_d = p0_d;
      p0_v = cv;
      p0_d = cd;
    end
  endtask

  initial begin
    aclk      = 1'b0;
    aresetn   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    inj       = 1'b0;
    p0_v = 1'b0; p1_v = 1'b0; p0_d = '0; p1_d = '0;
    m_ptr = N - 1;
    m_err = 1'b0;
    n_cmp = 0;
    n_bad = 0;

    // Reset state
    repeat (2) tick();
    aresetn = 1'b1;
    tick();

    // Single requester 2, data 0x1
    res_ready = 1'b1;
    req_data  = '0;
    req_data[2*DIN +: DIN] = DIN'(1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (6) tick();

    // All requesters continuously valid, consumer always ready
    req_valid = '1;
    repeat (16) begin
      req_data = rnd_data();
      tick();
    end

    // Backpressure, then release
    res_ready = 1'b0;
    repeat (8) begin
      req_data = rnd_data();
      tick();
    end
    res_ready = 1'b1;
    repeat (8) begin
      req_data = rnd_data();
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // Random traffic and backpressure across pointer wrap
    repeat (40) begin
      req_valid = N'($urandom);
      res_ready = 1'($urandom);
      req_data  = rnd_data();
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (8) tick();

    // Stray core strobe with nothing in flight
    inj = 1'b1;
    tick();
    inj = 1'b0;
    repeat (3) tick();
    check("err_sticky", 64'(err), 64'd1);
    check("res_valid_after_err", 64'(res_valid), 64'd0);

    // Reset mid-operation with results in flight and buffered
    res_ready = 1'b0;
    req_valid = '1;
    repeat (5) begin
      req_data = rnd_data();
      tick();
    end
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    req_valid = '1;
    req_data  = rnd_data();
    res_ready = 1'b1;
    repeat (10) tick();
    req_valid = '0;
    repeat (6) tick();
    check("err_after_reset", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
